// File: rtl/fsic_io_serdes_pkg.sv
// Shared types and constants for the IO SERDES receive-path link-training controller.
package fsic_io_serdes_pkg;

    localparam int         CLK_RATIO     = 4;
    localparam logic [3:0] TRAIN_PATTERN = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EN_WAIT = 3'd1,
        ST_HUNT    = 3'd2,
        ST_VERIFY  = 3'd3,
        ST_LINK_UP = 3'd4,
        ST_FAIL    = 3'd5
    } rx_state_e;

    // Lowest rotation whose comparator fired; callers only use it when some bit is set.
    function automatic logic [1:0] lowest_match(input logic [3:0] match);
        logic [1:0] idx;
        if (match[0]) begin
            idx = 2'd0;
        end else if (match[1]) begin
            idx = 2'd1;
        end else if (match[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fsic_io_serdes_word_align.sv
// Two-word history window, four rotation candidates and their training-pattern comparators.
module fsic_io_serdes_word_align
    import fsic_io_serdes_pkg::*;
#(
    parameter logic [3:0] pTRAIN_PATTERN = TRAIN_PATTERN
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_rxdata,
    input  logic       i_rxdata_valid,
    input  logic [1:0] i_sel,
    output logic [3:0] o_match,
    output logic [3:0] o_word
);

    logic [3:0] r_prev;
    logic [7:0] w_window;
    logic [3:0] w_cand [4];

    // History register: the previous valid word supplies the older bits of each rotation.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 4'h0;
        end else if (i_rxdata_valid) begin
            r_prev <= i_rxdata;
        end else begin
            r_prev <= r_prev;
        end
    end

    assign w_window  = {i_rxdata, r_prev};
    assign w_cand[0] = w_window[7:4];
    assign w_cand[1] = w_window[6:3];
    assign w_cand[2] = w_window[5:2];
    assign w_cand[3] = w_window[4:1];

    assign o_match[0] = (w_cand[0] == pTRAIN_PATTERN);
    assign o_match[1] = (w_cand[1] == pTRAIN_PATTERN);
    assign o_match[2] = (w_cand[2] == pTRAIN_PATTERN);
    assign o_match[3] = (w_cand[3] == pTRAIN_PATTERN);
    assign o_word     = w_cand[i_sel];

endmodule

// File: rtl/fsic_io_serdes_rx_ctrl.sv
// Receive link-training FSM: enables the receiver, hunts the training nibble rotation,
// verifies lock and then forwards word-aligned data with link_up.
module fsic_io_serdes_rx_ctrl
    import fsic_io_serdes_pkg::*;
#(
    parameter int         pCLK_RATIO     = CLK_RATIO,
    parameter logic [3:0] pTRAIN_PATTERN = TRAIN_PATTERN,
    parameter int         pLOCK_CNT      = 8,
    parameter int         pEN_TIMEOUT    = 32,
    parameter int         pHUNT_TIMEOUT  = 64
) (
    input  logic                          coreclk,
    input  logic                          axis_rst_n,
    input  logic                          cfg_train_en,
    input  logic                          cfg_retrain,
    input  logic [3:0]                    rxdata_in,
    input  logic                          rxdata_in_valid,
    output logic                          rxen,
    output logic [3:0]                    aligned_data,
    output logic                          aligned_valid,
    output logic                          link_up,
    output logic                          train_fail,
    output logic [$clog2(pCLK_RATIO)-1:0] align_offset
);

    localparam int EN_W   = $clog2(pEN_TIMEOUT + 1);
    localparam int HUNT_W = $clog2(pHUNT_TIMEOUT + 1);
    localparam int LOCK_W = $clog2(pLOCK_CNT + 1);
    localparam logic [EN_W-1:0]   EN_MAX   = EN_W'(pEN_TIMEOUT);
    localparam logic [HUNT_W-1:0] HUNT_MAX = HUNT_W'(pHUNT_TIMEOUT);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(pLOCK_CNT);

    rx_state_e         r_state;
    logic [EN_W-1:0]   r_en_cnt;
    logic [HUNT_W-1:0] r_hunt_cnt;
    logic [LOCK_W-1:0] r_match_cnt;
    logic              r_rxen;
    logic [3:0]        r_aligned_data;
    logic              r_aligned_valid;
    logic              r_link_up;
    logic              r_train_fail;
    logic [1:0]        r_align_offset;

    logic [3:0]        w_match;
    logic [3:0]        w_word;
    logic              w_hit_sel;
    logic [EN_W-1:0]   w_en_inc;
    logic [HUNT_W-1:0] w_hunt_inc;
    logic [LOCK_W-1:0] w_match_inc;

    fsic_io_serdes_word_align #(
        .pTRAIN_PATTERN (pTRAIN_PATTERN)
    ) u_word_align (
        .i_clk          (coreclk),
        .i_rst_n        (axis_rst_n),
        .i_rxdata       (rxdata_in),
        .i_rxdata_valid (rxdata_in_valid),
        .i_sel          (r_align_offset),
        .o_match        (w_match),
        .o_word         (w_word)
    );

    assign w_hit_sel   = w_match[r_align_offset];
    assign w_en_inc    = (r_en_cnt == EN_MAX) ? r_en_cnt : r_en_cnt + EN_W'(1);
    assign w_hunt_inc  = (r_hunt_cnt == HUNT_MAX) ? r_hunt_cnt : r_hunt_cnt + HUNT_W'(1);
    assign w_match_inc = (r_match_cnt == LOCK_MAX) ? r_match_cnt : r_match_cnt + LOCK_W'(1);

    // Training FSM with its counters and all registered outputs.
    always_ff @(posedge coreclk) begin
        if (!axis_rst_n) begin
            r_state         <= ST_IDLE;
            r_en_cnt        <= '0;
            r_hunt_cnt      <= '0;
            r_match_cnt     <= '0;
            r_rxen          <= 1'b0;
            r_aligned_data  <= 4'h0;
            r_aligned_valid <= 1'b0;
            r_link_up       <= 1'b0;
            r_train_fail    <= 1'b0;
            r_align_offset  <= 2'd0;
        end else if (!cfg_train_en) begin
            r_state         <= ST_IDLE;
            r_en_cnt        <= '0;
            r_hunt_cnt      <= '0;
            r_match_cnt     <= '0;
            r_rxen          <= 1'b0;
            r_aligned_valid <= 1'b0;
            r_link_up       <= 1'b0;
            r_train_fail    <= 1'b0;
        end else begin
            r_aligned_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_en_cnt    <= '0;
                    r_hunt_cnt  <= '0;
                    r_match_cnt <= '0;
                    r_rxen      <= 1'b1;
                    r_state     <= ST_EN_WAIT;
                end
                ST_EN_WAIT: begin
                    if (rxdata_in_valid) begin
                        r_hunt_cnt <= '0;
                        r_state    <= ST_HUNT;
                    end else if (w_en_inc == EN_MAX) begin
                        r_rxen       <= 1'b0;
                        r_train_fail <= 1'b1;
                        r_state      <= ST_FAIL;
                    end else begin
                        r_en_cnt <= w_en_inc;
                    end
                end
                ST_HUNT: begin
                    if (rxdata_in_valid) begin
                        r_hunt_cnt <= w_hunt_inc;
                        if (|w_match) begin
                            r_align_offset <= lowest_match(w_match);
                            r_match_cnt    <= LOCK_W'(1);
                            r_state        <= ST_VERIFY;
                        end else if (w_hunt_inc == HUNT_MAX) begin
                            r_rxen       <= 1'b0;
                            r_train_fail <= 1'b1;
                            r_state      <= ST_FAIL;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (rxdata_in_valid) begin
                        r_hunt_cnt <= w_hunt_inc;
                        if (w_hit_sel) begin
                            r_match_cnt <= w_match_inc;
                            if (w_match_inc == LOCK_MAX) begin
                                r_link_up <= 1'b1;
                                r_state   <= ST_LINK_UP;
                            end
                        end else begin
                            // The word timer is not restarted, so a flapping lock still times out.
                            r_match_cnt <= '0;
                            if (w_hunt_inc == HUNT_MAX) begin
                                r_rxen       <= 1'b0;
                                r_train_fail <= 1'b1;
                                r_state      <= ST_FAIL;
                            end else begin
                                r_state <= ST_HUNT;
                            end
                        end
                    end
                end
                ST_LINK_UP: begin
                    if (!rxdata_in_valid) begin
                        r_rxen       <= 1'b0;
                        r_link_up    <= 1'b0;
                        r_train_fail <= 1'b1;
                        r_state      <= ST_FAIL;
                    end else if (cfg_retrain) begin
                        r_hunt_cnt  <= '0;
                        r_match_cnt <= '0;
                        r_link_up   <= 1'b0;
                        r_state     <= ST_HUNT;
                    end else begin
                        r_aligned_valid <= 1'b1;
                        r_aligned_data  <= w_word;
                    end
                end
                ST_FAIL: begin
                    r_rxen       <= 1'b0;
                    r_train_fail <= 1'b1;
                end
                default: begin
                    r_rxen       <= 1'b0;
                    r_link_up    <= 1'b0;
                    r_train_fail <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign rxen          = r_rxen;
    assign aligned_data  = r_aligned_data;
    assign aligned_valid = r_aligned_valid;
    assign link_up       = r_link_up;
    assign train_fail    = r_train_fail;
    assign align_offset  = r_align_offset;

endmodule

// File: tb/tb_fsic_io_serdes_rx_ctrl.sv
// Directed self-checking bench for the IO SERDES receive link-training controller.
module tb_fsic_io_serdes_rx_ctrl;

    logic       coreclk = 1'b0;
    logic       axis_rst_n;
    logic       cfg_train_en;
    logic       cfg_retrain;
    logic [3:0] rxdata_in;
    logic       rxdata_in_valid;
    logic       rxen;
    logic [3:0] aligned_data;
    logic       aligned_valid;
    logic       link_up;
    logic       train_fail;
    logic [1:0] align_offset;

    int err_cnt = 0;
    int chk_cnt = 0;

    fsic_io_serdes_rx_ctrl dut (
        .coreclk         (coreclk),
        .axis_rst_n      (axis_rst_n),
        .cfg_train_en    (cfg_train_en),
        .cfg_retrain     (cfg_retrain),
        .rxdata_in       (rxdata_in),
        .rxdata_in_valid (rxdata_in_valid),
        .rxen            (rxen),
        .aligned_data    (aligned_data),
        .aligned_valid   (aligned_valid),
        .link_up         (link_up),
        .train_fail      (train_fail),
        .align_offset    (align_offset)
    );

    always #5 coreclk = ~coreclk;

    task automatic tick();
        @(posedge coreclk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rxen"},   32'(rxen),          32'd0);
        check_eq({tag, "_adata"},  32'(aligned_data),  32'd0);
        check_eq({tag, "_avalid"}, 32'(aligned_valid), 32'd0);
        check_eq({tag, "_link"},   32'(link_up),       32'd0);
        check_eq({tag, "_fail"},   32'(train_fail),    32'd0);
        check_eq({tag, "_ofs"},    32'(align_offset),  32'd0);
    endtask

    // From IDLE with a continuous pattern stream: EN_WAIT, HUNT hit, 7 verifies, link_up.
    task automatic lock_from_idle(input string tag, input logic [3:0] pat);
        cfg_train_en    = 1'b1;
        rxdata_in_valid = 1'b1;
        rxdata_in       = pat;
        tick();
        tick();
        tick();
        repeat (6) tick();
        check_eq({tag, "_link_early"}, 32'(link_up), 32'd0);
        tick();
        check_eq({tag, "_link"}, 32'(link_up), 32'd1);
    endtask

    initial begin
        axis_rst_n      = 1'b0;
        cfg_train_en    = 1'b0;
        cfg_retrain     = 1'b0;
        rxdata_in       = 4'h0;
        rxdata_in_valid = 1'b0;
        tick();
        tick();
        axis_rst_n = 1'b1;
        check_idle_outputs("reset");

        // Offset 0: valid arrives after three cycles of enable.
        cfg_train_en = 1'b1;
        tick();
        check_eq("en_rxen", 32'(rxen), 32'd1);
        tick();
        tick();
        rxdata_in_valid = 1'b1;
        rxdata_in       = 4'h3;
        tick();
        tick();
        repeat (6) tick();
        check_eq("ofs0_link_early", 32'(link_up), 32'd0);
        tick();
        check_eq("ofs0_link", 32'(link_up), 32'd1);
        check_eq("ofs0_ofs", 32'(align_offset), 32'd0);
        check_eq("ofs0_avalid_entry", 32'(aligned_valid), 32'd0);
        tick();
        check_eq("ofs0_avalid", 32'(aligned_valid), 32'd1);
        check_eq("ofs0_adata", 32'(aligned_data), 32'd3);

        // Retrain drops link and valid immediately, then relocks.
        cfg_retrain = 1'b1;
        tick();
        cfg_retrain = 1'b0;
        check_eq("rt_link", 32'(link_up), 32'd0);
        check_eq("rt_avalid", 32'(aligned_valid), 32'd0);
        check_eq("rt_rxen", 32'(rxen), 32'd1);
        repeat (7) tick();
        check_eq("rt_link_early", 32'(link_up), 32'd0);
        tick();
        check_eq("rt_relock", 32'(link_up), 32'd1);

        // Valid drop in LINK_UP fails the link.
        rxdata_in_valid = 1'b0;
        tick();
        check_eq("drop_fail", 32'(train_fail), 32'd1);
        check_eq("drop_link", 32'(link_up), 32'd0);
        check_eq("drop_rxen", 32'(rxen), 32'd0);
        check_eq("drop_avalid", 32'(aligned_valid), 32'd0);
        cfg_train_en = 1'b0;
        tick();
        check_eq("drop_clr", 32'(train_fail), 32'd0);

        // Offset 2: 4'hC stream holds the pattern two bits into the window.
        lock_from_idle("ofs2", 4'hC);
        check_eq("ofs2_ofs", 32'(align_offset), 32'd2);
        rxdata_in = 4'hA;
        tick();
        check_eq("ofs2_avalid", 32'(aligned_valid), 32'd1);
        check_eq("ofs2_pay_a", 32'(aligned_data), 32'hB);
        rxdata_in = 4'h5;
        tick();
        check_eq("ofs2_pay_5", 32'(aligned_data), 32'h6);

        // Simultaneous retrain and valid drop resolves to FAIL.
        cfg_retrain     = 1'b1;
        rxdata_in_valid = 1'b0;
        tick();
        cfg_retrain = 1'b0;
        check_eq("both_fail", 32'(train_fail), 32'd1);
        check_eq("both_link", 32'(link_up), 32'd0);
        cfg_train_en = 1'b0;
        tick();

        // VERIFY mismatch after 5 matches forces a full re-verify.
        cfg_train_en    = 1'b1;
        rxdata_in_valid = 1'b1;
        rxdata_in       = 4'h3;
        tick();
        tick();
        tick();
        repeat (4) tick();
        rxdata_in = 4'hF;
        tick();
        check_eq("mm_link", 32'(link_up), 32'd0);
        rxdata_in = 4'h3;
        tick();
        repeat (6) tick();
        check_eq("mm_link_early", 32'(link_up), 32'd0);
        tick();
        check_eq("mm_relock", 32'(link_up), 32'd1);
        check_eq("mm_ofs", 32'(align_offset), 32'd0);
        cfg_train_en = 1'b0;
        tick();

        // Enable timeout: 32 cycles in EN_WAIT without valid.
        rxdata_in_valid = 1'b0;
        cfg_train_en    = 1'b1;
        tick();
        repeat (31) tick();
        check_eq("ento_early", 32'(train_fail), 32'd0);
        tick();
        check_eq("ento_fail", 32'(train_fail), 32'd1);
        check_eq("ento_rxen", 32'(rxen), 32'd0);
        cfg_train_en = 1'b0;
        tick();
        check_eq("ento_clr", 32'(train_fail), 32'd0);

        // Hunt timeout: 64 non-pattern words alternating F/E.
        cfg_train_en    = 1'b1;
        rxdata_in_valid = 1'b1;
        rxdata_in       = 4'hF;
        tick();
        tick();
        for (int i = 0; i < 63; i++) begin
            rxdata_in = i[0] ? 4'hE : 4'hF;
            tick();
        end
        check_eq("hto_early", 32'(train_fail), 32'd0);
        rxdata_in = 4'hE;
        tick();
        check_eq("hto_fail", 32'(train_fail), 32'd1);
        check_eq("hto_rxen", 32'(rxen), 32'd0);
        cfg_train_en = 1'b0;
        tick();
        check_eq("hto_clr", 32'(train_fail), 32'd0);
        check_eq("hto_clr_rxen", 32'(rxen), 32'd0);

        // Reset in the middle of VERIFY with offset 2 latched.
        cfg_train_en    = 1'b1;
        rxdata_in_valid = 1'b1;
        rxdata_in       = 4'hC;
        repeat (5) tick();
        check_eq("rstv_ofs_pre", 32'(align_offset), 32'd2);
        axis_rst_n = 1'b0;
        tick();
        axis_rst_n = 1'b1;
        check_idle_outputs("rstv");
        tick();
        tick();
        tick();
        repeat (6) tick();
        check_eq("rstv_link_early", 32'(link_up), 32'd0);
        tick();
        check_eq("rstv_relock", 32'(link_up), 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
